// File: rtl/serial_demux_rx.sv
// Serial frame receiver/demux: start, ADDR_W addr bits, LEN_W length bits, L data bits, [parity], stop.
// Latency: each data bit appears on ch_valid/ch_bit one clk after it is sampled.
// Backpressure: none; the line is sampled every clk. Optional PARITY_EN adds an even-parity bit.
module serial_demux_rx #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   serial_in,
    output logic [2**ADDR_W-1:0]   ch_valid,
    output logic                   ch_bit,
    output logic [ADDR_W-1:0]      ch_addr,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   error
);

    localparam int NUM_CH = 2**ADDR_W;
    localparam int CNT_W  = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;

`ifdef PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_STOP, S_ERR, S_PAR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_STOP, S_ERR} state_t;
`endif

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   ch_addr_q, ch_addr_d;
    logic [NUM_CH-1:0]   ch_valid_q, ch_valid_d;
    logic                ch_bit_q, ch_bit_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic                error_q, error_d;
`ifdef PARITY_EN
    logic                par_q, par_d;
`endif

    // Shift-in views of the fields including the bit on the line this cycle (MSB first).
    logic [ADDR_W-1:0]   addr_next;
    logic [LEN_W-1:0]    len_next;
    assign addr_next = (addr_sh_q << 1) | ADDR_W'(serial_in);
    assign len_next  = (len_q << 1) | LEN_W'(serial_in);

    // State and output registers; reset aborts any frame without a done/error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_sh_q    <= '0;
            len_q        <= '0;
            ch_addr_q    <= '0;
            ch_valid_q   <= '0;
            ch_bit_q     <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            error_q      <= 1'b0;
`ifdef PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_sh_q    <= addr_sh_d;
            len_q        <= len_d;
            ch_addr_q    <= ch_addr_d;
            ch_valid_q   <= ch_valid_d;
            ch_bit_q     <= ch_bit_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            error_q      <= error_d;
`ifdef PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

    // Next-state and registered-output decode; the bit counter reloads on each state entry.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_sh_d    = addr_sh_q;
        len_d        = len_q;
        ch_addr_d    = ch_addr_q;
        ch_valid_d   = '0;
        ch_bit_d     = 1'b0;
        frame_done_d = 1'b0;
`ifdef PARITY_EN
        par_d        = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!serial_in) begin
                    state_d   = S_ADDR;
                    cnt_d     = CNT_W'(ADDR_W - 1);
                    addr_sh_d = '0;
                    len_d     = '0;
`ifdef PARITY_EN
                    par_d     = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                addr_sh_d = addr_next;
`ifdef PARITY_EN
                par_d     = par_q ^ serial_in;
`endif
                if (cnt_q == '0) begin
                    ch_addr_d = addr_next;
                    state_d   = S_LEN;
                    cnt_d     = CNT_W'(LEN_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LEN: begin
                len_d = len_next;
`ifdef PARITY_EN
                par_d = par_q ^ serial_in;
`endif
                if (cnt_q == '0) begin
                    if (len_next != '0) begin
                        state_d = S_DATA;
                        cnt_d   = CNT_W'(len_next) - CNT_W'(1);
                    end else begin
`ifdef PARITY_EN
                        state_d = S_PAR;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DATA: begin
                ch_valid_d = NUM_CH'(1) << ch_addr_q;
                ch_bit_d   = serial_in;
`ifdef PARITY_EN
                par_d      = par_q ^ serial_in;
`endif
                if (cnt_q == '0) begin
`ifdef PARITY_EN
                    state_d = S_PAR;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef PARITY_EN
            S_PAR: begin
                // Even parity: the running XOR plus the parity bit must be zero.
                if (par_q ^ serial_in) state_d = S_ERR;
                else                   state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (serial_in) begin
                    state_d      = S_IDLE;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                // Start bits (low) keep us here; a high line releases to IDLE.
                if (serial_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d  = (state_d != S_IDLE);
        error_d = (state_d == S_ERR);
    end

    assign ch_valid   = ch_valid_q;
    assign ch_bit     = ch_bit_q;
    assign ch_addr    = ch_addr_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign error      = error_q;

endmodule
